// File: rtl/itrx_aib_phy_pkg.sv
// Shared definitions for the AIB PHY boundary-scan sequencer: chain geometry,
// per-cell bit positions and the sequencer state encoding.
package itrx_aib_phy_pkg;

    localparam int unsigned BSR_BITS_PER_CELL = 12;

    // Bit positions within one IO cell, counted from the scanout end.
    localparam int unsigned POS_ODAT_ASYN = 0;
    localparam int unsigned POS_OCLK      = 1;
    localparam int unsigned POS_OCLK_B    = 2;
    localparam int unsigned POS_ODAT1     = 3;
    localparam int unsigned POS_ODAT0     = 4;
    localparam int unsigned POS_RXEN0     = 5;
    localparam int unsigned POS_RXEN1     = 6;
    localparam int unsigned POS_RXEN2     = 7;
    localparam int unsigned POS_TXEN      = 8;
    localparam int unsigned POS_ASYNC     = 9;
    localparam int unsigned POS_IDAT1     = 10;
    localparam int unsigned POS_IDAT0     = 11;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlo  = 3'd1,
        StPhi  = 3'd2,
        StTail = 3'd3,
        StEnd  = 3'd4
    } bsr_seq_state_e;

    function automatic int unsigned bsr_chain_len(input int unsigned num_cells);
        return num_cells * BSR_BITS_PER_CELL;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_bsr_clkgen.sv
// Phase timer and registered scan clock for the BSR sequencer. Every timed
// phase lasts exactly CLK_DIV cycles; clkdr comes straight from a flop.
module itrx_aib_phy_bsr_clkgen #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic jtag_clk,
    input  logic jtag_rstn,
    input  logic run,
    input  logic clkdr_next,
    output logic phase_end,
    output logic is_high
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clkdr_q;

    always_comb begin
        phase_end = run && (cnt_q == LAST_CNT);
        cnt_d     = (!run || phase_end) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge jtag_clk or negedge jtag_rstn) begin
        if (!jtag_rstn) begin
            cnt_q   <= '0;
            clkdr_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clkdr_q <= clkdr_next;
        end
    end

    assign is_high = clkdr_q;

endmodule

// File: rtl/itrx_aib_phy_bsr_seq.sv
// Boundary-scan sequencer: optional capture pulse followed by CHAIN_LEN shift
// pulses through a daisy-chain of AIB IO BSRs, all outputs registered.
module itrx_aib_phy_bsr_seq
    import itrx_aib_phy_pkg::*;
#(
    parameter int unsigned  NUM_CELLS = 2,
    parameter int unsigned  CLK_DIV   = 1,
    localparam int unsigned CHAIN_LEN = bsr_chain_len(NUM_CELLS)
) (
    input  logic                 jtag_clk,
    input  logic                 jtag_rstn,
    input  logic                 start,
    input  logic                 op_capture,
    input  logic                 mode_req,
    input  logic                 intest_req,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] tdi_vec,
    output logic                 ready,
    output logic                 done,
    output logic                 aborted,
    output logic [CHAIN_LEN-1:0] tdo_vec,
    output logic                 jtag_clkdr,
    output logic                 jtag_scan_en,
    output logic                 jtag_mode,
    output logic                 jtag_intest,
    output logic                 jtag_scanin,
    input  logic                 jtag_scanout
);

    localparam int unsigned PW = $clog2(CHAIN_LEN + 2);

    bsr_seq_state_e       state_q, state_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [CHAIN_LEN-1:0] tdo_vec_q, tdo_vec_d;
    logic [PW-1:0]        rem_q, rem_d;
    logic                 tdo_bit_q, tdo_bit_d;
    logic                 cap_q, cap_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 scan_en_q, scan_en_d;
    logic                 mode_q, mode_d;
    logic                 intest_q, intest_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic                 ready_q, ready_d;
    logic                 phase_end;
    logic                 clkdr_high;
    logic                 run;
    logic                 clkdr_next;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        tdo_vec_d    = tdo_vec_q;
        rem_d        = rem_q;
        tdo_bit_d    = tdo_bit_q;
        cap_d        = cap_q;
        abort_pend_d = abort_pend_q;
        scan_en_d    = scan_en_q;
        mode_d       = mode_q;
        intest_d     = intest_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d         = tdi_vec;
                    mode_d       = mode_req;
                    intest_d     = intest_req;
                    cap_d        = op_capture;
                    rem_d        = PW'(CHAIN_LEN) + {{(PW-1){1'b0}}, op_capture};
                    scan_en_d    = !op_capture;
                    abort_pend_d = 1'b0;
                    state_d      = StPlo;
                end
            end
            StPlo: begin
                if (abort) begin
                    state_d   = StEnd;
                    aborted_d = 1'b1;
                    scan_en_d = 1'b0;
                end else if (phase_end) begin
                    if (!cap_q) tdo_bit_d = jtag_scanout;
                    state_d = StPhi;
                end
            end
            StPhi: begin
                if (abort) abort_pend_d = 1'b1;
                if (phase_end) begin
                    // An abort seen anywhere in the high phase lets it finish, but drops the shift.
                    if (abort || abort_pend_q) begin
                        state_d   = StEnd;
                        aborted_d = 1'b1;
                        scan_en_d = 1'b0;
                    end else begin
                        if (!cap_q) sr_d = {tdo_bit_q, sr_q[CHAIN_LEN-1:1]};
                        cap_d = 1'b0;
                        rem_d = rem_q - PW'(1);
                        if (rem_q == PW'(1)) begin
                            state_d = StTail;
                        end else begin
                            state_d   = StPlo;
                            scan_en_d = 1'b1;
                        end
                    end
                end
            end
            StTail: begin
                // Completion takes priority over an abort in the final tail cycle.
                if (phase_end) begin
                    state_d   = StEnd;
                    done_d    = 1'b1;
                    tdo_vec_d = sr_q;
                    scan_en_d = 1'b0;
                end else if (abort) begin
                    state_d   = StEnd;
                    aborted_d = 1'b1;
                    scan_en_d = 1'b0;
                end
            end
            StEnd: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge jtag_clk or negedge jtag_rstn) begin
        if (!jtag_rstn) begin
            state_q      <= StIdle;
            sr_q         <= '0;
            tdo_vec_q    <= '0;
            rem_q        <= '0;
            tdo_bit_q    <= 1'b0;
            cap_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            scan_en_q    <= 1'b0;
            mode_q       <= 1'b0;
            intest_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            tdo_vec_q    <= tdo_vec_d;
            rem_q        <= rem_d;
            tdo_bit_q    <= tdo_bit_d;
            cap_q        <= cap_d;
            abort_pend_q <= abort_pend_d;
            scan_en_q    <= scan_en_d;
            mode_q       <= mode_d;
            intest_q     <= intest_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            ready_q      <= ready_d;
        end
    end

    assign run        = (state_q == StPlo) || (state_q == StPhi) || (state_q == StTail);
    assign clkdr_next = (state_d == StPhi);

    itrx_aib_phy_bsr_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .jtag_clk   (jtag_clk),
        .jtag_rstn  (jtag_rstn),
        .run        (run),
        .clkdr_next (clkdr_next),
        .phase_end  (phase_end),
        .is_high    (clkdr_high)
    );

    assign ready        = ready_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign tdo_vec      = tdo_vec_q;
    assign jtag_clkdr   = clkdr_high;
    assign jtag_scan_en = scan_en_q;
    assign jtag_mode    = mode_q;
    assign jtag_intest  = intest_q;
    assign jtag_scanin  = sr_q[0];

endmodule

// File: doc/itrx_aib_phy_bsr_seq.md
Name: itrx_aib_phy_bsr_seq

Overview:
- Scan sequencer for a daisy-chain of NUM_CELLS AIB IO boundary-scan registers, 12 bits per IO cell.
- Generates a glitch-free divided jtag_clkdr and drives jtag_scan_en, jtag_mode, jtag_intest and jtag_scanin.
- Runs an optional capture pulse, then CHAIN_LEN shift pulses, serialising a parallel load vector in and the chain contents out.
- Sits between the register/JTAG control logic and the first IO cell's scan input / last cell's scan output.

Parameters:
NUM_CELLS, 2, number of chained IO BSRs
CHAIN_LEN, 12*NUM_CELLS (localparam), total chain bits
CLK_DIV, 1, jtag_clk cycles per clkdr phase (low or high); legal range >=1

Ports:
jtag_clk  in  1  sequencer clock
jtag_rstn  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
op_capture  in  1  sampled at start; 1 = issue one capture pulse before shifting
mode_req  in  1  sampled at start; value for jtag_mode
intest_req  in  1  sampled at start; value for jtag_intest
abort  in  1  synchronous abort of a running sequence
tdi_vec  in  CHAIN_LEN  load data; bit i lands at chain position i counted from the scanout end
ready  out  1  sequencer idle
done  out  1  one-cycle pulse: sequence completed, tdo_vec valid
aborted  out  1  one-cycle pulse: sequence terminated by abort
tdo_vec  out  CHAIN_LEN  shifted-out data; bit i = chain position i before the shift
jtag_clkdr  out  1  BSR scan clock, driven directly from a flop
jtag_scan_en  out  1  0 = capture, 1 = shift
jtag_mode  out  1  BSR output-override select
jtag_intest  out  1  BSR intest select
jtag_scanin  out  1  serial data to first cell
jtag_scanout  in  1  serial data from last cell (changes on clkdr negedge)

Behaviour:
- Reset (async, jtag_rstn=0): every output is 0 immediately, except ready, which is 1 after reset is released. tdo_vec=0. State is IDLE.
- States: IDLE, PLO (pulse low phase), PHI (pulse high phase), TAIL, END.
- Each phase lasts CLK_DIV cycles, counted by a phase counter.
- Start:
  - start & ready in cycle 0 latches tdi_vec into shift register sr, and latches mode_req→jtag_mode and intest_req→jtag_intest.
  - Pulse count P = CHAIN_LEN + op_capture.
  - Enter PLO in cycle 1. ready=0 from cycle 1.
  - start while ready=0 is ignored.
- jtag_scan_en:
  - Updates only on entry to PLO.
  - 0 for the capture pulse, 1 for shift pulses.
- PLO:
  - jtag_clkdr=0 and jtag_scanin=sr[0], both stable.
  - For shift pulses, on the last cycle of PLO: tdo_bit <= jtag_scanout.
- PHI:
  - jtag_clkdr=1.
  - At end of PHI for shift pulses: sr <= {tdo_bit, sr[CHAIN_LEN-1:1]}. sr changes only on the clkdr falling edge, so scanin never changes on the rising edge.
- After pulse P the sequencer enters TAIL: one low phase with scan_en unchanged, then END.
- END, one cycle:
  - tdo_vec <= sr, done=1, jtag_scan_en<=0.
  - Next cycle is IDLE with ready=1.
- Latency: done is high in cycle (2P+1)*CLK_DIV + 1 after the start cycle. Default with capture: 52.
- jtag_mode and jtag_intest hold their latched values after completion, until the next accepted start.
- Abort:
  - In PLO or TAIL: go to END-abort next cycle.
  - In PHI: finish the current high phase with no sr update, then END-abort.
  - END-abort: aborted=1, done=0, tdo_vec unchanged, scan_en=0, clkdr=0.
  - abort while IDLE has no effect.
  - abort and completion in the same cycle: completion wins.
- jtag_clkdr is never high for fewer than CLK_DIV cycles and has no glitches; no combinational path to any output.
- Counter widths: $clog2(CHAIN_LEN+2) for the pulse counter, $clog2(CLK_DIV+1) for the phase counter.

Decomposition:
- Package itrx_aib_phy_pkg:
  - BSR_BITS_PER_CELL=12.
  - State encoding constants.
  - Chain bit-position constants, e.g. POS_ODAT_ASYN=0, POS_OCLK=1, POS_OCLK_B=2, POS_ODAT1=3, POS_ODAT0=4, POS_RXEN0..2=5..7, POS_TXEN=8, POS_ASYNC=9, POS_IDAT1=10, POS_IDAT0=11.
- One sub-module: itrx_aib_phy_bsr_clkgen, containing the phase counter and clkdr flop, emitting phase_end and is_high.

Test Plan:
- Shift-only, two chained BSR models, CLK_DIV=1: shift tdi=24'hA5C35A, then shift tdi=24'h000000 → second done gives tdo_vec=24'hA5C35A; 24 clkdr pulses each; scan_en=1 throughout.
- Capture+shift: all rmux_* inputs=1, all nrml_* inputs=0, intest_req=0 → 25 pulses, first with scan_en=0; tdo_vec=24'h01F01F; done in cycle 52.
- CLK_DIV=2 with capture → every clkdr high/low phase is 2 cycles; done in cycle 103; jtag_scanin is constant across every clkdr rising edge.
- start pulsed during busy at cycle 10 → ignored, exactly one done. start in the cycle after done (ready=1) → accepted; new mode_req=1 appears on jtag_mode.
- abort asserted during the high phase of shift pulse 5 → clkdr falls at the normal phase end, aborted pulse 1 cycle later, done never asserts, tdo_vec retains its previous value, scan_en=0.
- jtag_rstn asserted mid-shift → clkdr, scan_en, scanin, mode, intest, done and aborted are 0 with no clock edge. After release: ready=1, tdo_vec=0.
